// File: rtl/fetch_decode_unit.sv
// -----------------------------------------------------------------------------
// fetch_decode_unit
//
// Fetches 16-bit instructions from instruction memory over a req/rvalid
// handshake and holds each one in an instruction register (IR). The IR fields
// are presented to the opcode decoder for one execute cycle. The PC is then
// advanced by one or loaded with a jump target, as chosen by the decoder's
// pc_sel. Opcode 4'hF (HALT) parks the unit until reset.
//
// Instruction lifecycle: FETCH (request) -> WAIT (until rvalid) -> EXEC (one
// cycle) -> FETCH. The minimum instruction period is therefore three cycles.
//
// Configuration macro:
//   FDU_ILLEGAL_TRAP_EN - when defined, opcodes 4'h8..4'hE trap to HALT and set
//                         the sticky illegal_op output. When undefined, those
//                         opcodes execute as NOPs and illegal_op does not exist.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   run_en       1 = allow new fetches
//   imem_req     one-cycle fetch request (FETCH with run_en)
//   imem_addr    fetch address, valid while imem_req=1
//   imem_rdata   instruction data, captured when imem_rvalid=1 in WAIT
//   imem_rvalid  read data valid
//   pc_sel       from decoder; 1 = jump to imm during EXEC
//   opcode       IR[15:12]
//   rd           IR[11:8]
//   imm          IR[7:0]
//   instr_valid  high exactly in the EXEC cycle
//   pc           current PC
//   halted       1 in HALT state
//   illegal_op   sticky illegal-opcode flag (FDU_ILLEGAL_TRAP_EN only)
// -----------------------------------------------------------------------------
module fetch_decode_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    input  logic               pc_sel,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [7:0]         imm,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
`ifdef FDU_ILLEGAL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      pc_nxt_s;
    logic [INSTR_W-1:0]   ir_r;
    logic [INSTR_W-1:0]   ir_nxt_s;
    logic                 illegal_r;
    logic                 illegal_nxt_s;
    logic [3:0]           op_s;
    logic                 illegal_s;

    assign op_s = ir_r[INSTR_W-1 -: 4];

`ifdef FDU_ILLEGAL_TRAP_EN
    // Opcodes 8..E are reserved and trap when the feature is enabled.
    assign illegal_s = (op_s >= 4'h8) && (op_s <= 4'hE);
`else
    assign illegal_s = 1'b0;
`endif

    // State, PC, IR and sticky trap flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            pc_r      <= {PC_W{1'b0}};
            ir_r      <= {INSTR_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            ir_r      <= ir_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    // Next-state logic: sequencing, IR capture and PC update.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        ir_nxt_s      = ir_r;
        illegal_nxt_s = illegal_r;
        case (state_r)
            ST_FETCH: begin
                if (run_en) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                // rvalid is only honoured here, so a response to a request
                // issued before reset can never land in the IR.
                if (imem_rvalid) begin
                    ir_nxt_s    = imem_rdata;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_EXEC: begin
                if (op_s == OP_HALT) begin
                    state_nxt_s = ST_HALT;
                end else if (illegal_s) begin
                    illegal_nxt_s = 1'b1;
                    state_nxt_s   = ST_HALT;
                end else begin
                    if (pc_sel) begin
                        pc_nxt_s = ir_r[PC_W-1:0];
                    end else begin
                        // Natural wrap modulo 2^PC_W.
                        pc_nxt_s = pc_r + PC_W'(1);
                    end
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // Outputs are decoded from registered state only; no path from rvalid.
    assign imem_req    = (state_r == ST_FETCH) && run_en;
    assign imem_addr   = pc_r;
    assign instr_valid = (state_r == ST_EXEC);
    assign halted      = (state_r == ST_HALT);
    assign pc          = pc_r;
    assign opcode      = op_s;
    assign rd          = ir_r[INSTR_W-5 -: 4];
    assign imm         = ir_r[7:0];

`ifdef FDU_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_r;
`else
    // Keep the flag register observable to lint when the port is absent.
    logic unused_illegal_s;
    assign unused_illegal_s = illegal_r;
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fetch_decode_unit. The bench plays the instruction
// memory itself and keeps a reference PC computed from the architectural rules
// (halt keeps PC, jump loads imm, otherwise PC+1 modulo 256).
// -----------------------------------------------------------------------------
module tb_fetch_decode_unit;

    logic        clk;
    logic        rst;
    logic        run_en;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic        pc_sel;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        halted;
`ifdef FDU_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    int          errors;
    int          checks;
    logic [7:0]  model_pc;
    int          last_wait;

    fetch_decode_unit #(.PC_W(8), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .pc_sel      (pc_sel),
        .opcode      (opcode),
        .rd          (rd),
        .imm         (imm),
        .instr_valid (instr_valid),
        .pc          (pc),
`ifdef FDU_ILLEGAL_TRAP_EN
        .illegal_op  (illegal_op),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference PC after executing an instruction.
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [15:0] ins, input logic sel);
        int op;
        op = int'(ins[15:12]);
        if (op == 15) return cur;
`ifdef FDU_ILLEGAL_TRAP_EN
        if (op >= 8) return cur;
`endif
        if (sel) return ins[7:0];
        return 8'((int'(cur) + 1) % 256);
    endfunction

    task automatic apply_reset();
        rst = 1'b1; run_en = 1'b0; imem_rvalid = 1'b0; pc_sel = 1'b0;
        imem_rdata = 16'h0000;
        step();
        step();
        rst = 1'b0;
        model_pc = 8'h00;
    endtask

    // One complete instruction: request, response after lat cycles, EXEC.
    // gap > 0 drops run_en for gap cycles after EXEC.
    task automatic do_instr(input logic [15:0] ins, input int lat, input logic sel, input int gap);
        int waited;
        logic [7:0] exp_pc;
        exp_pc = model_next(model_pc, ins, sel);
        #1;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        last_wait = waited;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, model_pc);
        end
        step();
        for (int i = 1; i <= lat; i++) begin
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_idle: req=%b valid=%b, expected 0 0 (cycle %0d)", imem_req, instr_valid, i);
            end
            if (i == lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ins;
            end
            step();
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        checks++;
        if (instr_valid !== 1'b1 || opcode !== ins[15:12] || rd !== ins[11:8] || imm !== ins[7:0]) begin
            errors++;
            $display("FAIL exec_fields: valid=%b op=%h rd=%h imm=%h, expected 1 %h %h %h",
                     instr_valid, opcode, rd, imm, ins[15:12], ins[11:8], ins[7:0]);
        end
        pc_sel = sel;
        if (gap > 0) run_en = 1'b0;
        step();
        pc_sel = 1'b0;
        checks++;
        if (pc !== exp_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL pc_update: pc=%h valid=%b, expected pc=%h valid=0", pc, instr_valid, exp_pc);
        end
        model_pc = exp_pc;
        if (gap > 0) begin
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_req: req=%b, expected 0", imem_req);
                end
                step();
            end
            run_en = 1'b1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (pc !== 8'h00 || halted !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            opcode !== 4'h0 || rd !== 4'h0 || imm !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: pc=%h halted=%b req=%b valid=%b op=%h rd=%h imm=%h, expected all 0",
                     pc, halted, imem_req, instr_valid, opcode, rd, imm);
        end
`ifdef FDU_ILLEGAL_TRAP_EN
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal: illegal_op=%b, expected 0", illegal_op);
        end
`endif
    endtask

    task automatic test_basic();
        apply_reset();
        run_en = 1'b1;
        do_instr(16'h1305, 1, 1'b0, 0);
        do_instr(16'h2000, 1, 1'b0, 0);
        checks++;
        if (last_wait !== 0) begin
            errors++;
            $display("FAIL back_to_back: second req after %0d extra cycles, expected 0", last_wait);
        end
    endtask

    task automatic test_delay();
        do_instr(16'h3456, 5, 1'b0, 0);
    endtask

    task automatic test_jump();
        do_instr(16'h7020, 1, 1'b1, 0);
        do_instr(16'h7044, 2, 1'b0, 0);
    endtask

    task automatic test_wrap();
        do_instr(16'h70FF, 1, 1'b1, 0);
        do_instr(16'h2ABC, 1, 1'b0, 0);
    endtask

    task automatic test_halt();
        int bad;
        logic [7:0] held_pc;
        do_instr(16'h7033, 1, 1'b1, 0);
        held_pc = model_pc;
        do_instr(16'hF000, 1, 1'b0, 0);
        checks++;
        if (halted !== 1'b1 || pc !== held_pc) begin
            errors++;
            $display("FAIL halt_enter: halted=%b pc=%h, expected 1 pc=%h", halted, pc, held_pc);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_rvalid = 1'($urandom);
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== held_pc) bad++;
            step();
        end
        imem_rvalid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL halt_park: %0d bad cycles, expected 0", bad);
        end
        apply_reset();
        checks++;
        if (halted !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h, expected 0 00", halted, pc);
        end
    endtask

    task automatic test_reset_in_wait();
        run_en = 1'b1;
        do_instr(16'h7050, 1, 1'b1, 0);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h50) begin
            errors++;
            $display("FAIL rst_wait_req: req=%b addr=%h, expected 1 50", imem_req, imem_addr);
        end
        step();
        rst = 1'b1; run_en = 1'b0;
        step();
        rst = 1'b0;
        model_pc = 8'h00;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h1ABC;
        step();
        imem_rvalid = 1'b0;
        step();
        checks++;
        if (opcode !== 4'h0 || imm !== 8'h00 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL stale_rvalid: op=%h imm=%h valid=%b req=%b pc=%h, expected 0 00 0 0 00",
                     opcode, imm, instr_valid, imem_req, pc);
        end
        run_en = 1'b1;
        do_instr(16'h4321, 1, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int n = 0; n < 40; n++) begin
`ifdef FDU_ILLEGAL_TRAP_EN
            ins[15:12] = 4'($urandom_range(0, 7));
`else
            ins[15:12] = 4'($urandom_range(0, 14));
`endif
            ins[11:0] = 12'($urandom);
            do_instr(ins, int'($urandom_range(1, 4)), 1'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

`ifdef FDU_ILLEGAL_TRAP_EN
    task automatic test_illegal();
        apply_reset();
        run_en = 1'b1;
        do_instr(16'h9000, 1, 1'b0, 0);
        checks++;
        if (illegal_op !== 1'b1 || halted !== 1'b1 || pc !== 8'h00) begin
            errors++;
            $display("FAIL illegal_trap: illegal_op=%b halted=%b pc=%h, expected 1 1 00", illegal_op, halted, pc);
        end
        apply_reset();
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: illegal_op=%b, expected 0", illegal_op);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        last_wait = 0;
        model_pc = 8'h00;
        test_reset();
        test_basic();
        test_delay();
        test_jump();
        test_wrap();
        test_halt();
        test_reset_in_wait();
        test_random();
`ifdef FDU_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
